// File: rtl/io_debounce_pkg.sv
// Shared types and helpers for the io_debounce block.
package io_pkg;

  typedef enum logic {
    STABLE,
    PEND
  } ch_state_e;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/io_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, tick-based stability FSM and
// optional long-press hold counter (IO_DEBOUNCE_LPRESS_EN).
module io_debounce_ch
  import io_pkg::*;
#(
  parameter bit          DS = 1'b0,
  parameter int unsigned DB = 10,
  parameter int unsigned LP = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in,
  output logic state,
  output logic rise,
  output logic fall,
  output logic lpress
);

  localparam int unsigned CW = width_of(DB + 1);

  logic [1:0]    sync_q;
  logic          sync;
  ch_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  assign sync = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {2{DS}};
      st_q    <= STABLE;
      cnt_q   <= '0;
      state_q <= DS;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], in};
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Any cycle where sync agrees with state aborts a pending change.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync == state_q) begin
      st_d  = STABLE;
      cnt_d = '0;
    end else begin
      st_d = PEND;
      if (tick) begin
        if (cnt_q == CW'(DB - 1)) begin
          st_d    = STABLE;
          cnt_d   = '0;
          state_d = sync;
          rise_d  = sync;
          fall_d  = ~sync;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  assign state = state_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef IO_DEBOUNCE_LPRESS_EN
  localparam int unsigned HW = width_of(LP + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          lpress_q, lpress_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q   <= '0;
      lpress_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      lpress_q <= lpress_d;
    end
  end

  // Saturates at LP so the pulse fires once per hold.
  always_comb begin
    hold_d   = hold_q;
    lpress_d = 1'b0;
    if (state_q == DS) begin
      hold_d = '0;
    end else if (tick && (hold_q != HW'(LP))) begin
      hold_d   = hold_q + 1'b1;
      lpress_d = (hold_q == HW'(LP - 1));
    end
  end

  assign lpress = lpress_q;
`else
  assign lpress = 1'b0;
`endif

endmodule

// File: rtl/io_debounce.sv
// Multi-channel button/switch debouncer with a shared tick prescaler.
// Long-press detection is built only when IO_DEBOUNCE_LPRESS_EN is defined.
module io_debounce
  import io_pkg::*;
#(
  parameter int unsigned SW   = 1,
  parameter bit          DS   = 1'b0,
  parameter int unsigned TICK = 1000,
  parameter int unsigned DB   = 10,
  parameter int unsigned LP   = 500
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] in,
  output logic [SW-1:0] state,
  output logic [SW-1:0] rise,
  output logic [SW-1:0] fall,
  output logic [SW-1:0] lpress
);

  localparam int unsigned PW = width_of(TICK);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == PW'(TICK - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < SW; i++) begin : g_ch
    io_debounce_ch #(
      .DS(DS),
      .DB(DB),
      .LP(LP)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .in    (in[i]),
      .state (state[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .lpress(lpress[i])
    );
  end

endmodule
